// File: rtl/mem_arbiter.sv
// Two-port (IF/DM) arbiter and sequencer for a shared single-port memory.
// DM has priority; IF is forced through after STARVE_LIMIT consecutive DM wins.
module mem_arbiter #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [DATA_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StResp = 2'd2} state_e;

    localparam logic [3:0] CntInit   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              owner_q, owner_d;  // 1 = DM, 0 = IF
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_win;

    assign dm_win = dm_req_i && !(if_req_i && (starve_q == StarveMax));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (if_req_i || dm_req_i) begin
                    owner_d = dm_win;
                    we_d    = dm_win & dm_we_i;
                    addr_d  = dm_win ? dm_addr_i : if_addr_i;
                    wdata_d = dm_win ? dm_wdata_i : wdata_q;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                    if (if_req_i && dm_win) begin
                        starve_d = (starve_q < StarveMax) ? starve_q + 4'd1 : starve_q;
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (!we_q) begin
                        if (owner_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // All memory-side strobes decode registered state only, so they never glitch.
    assign if_gnt_o      = (state_q != StIdle) & ~owner_q;
    assign dm_gnt_o      = (state_q != StIdle) & owner_q;
    assign if_done_o     = (state_q == StResp) & ~owner_q;
    assign dm_done_o     = (state_q == StResp) & owner_q;
    assign mem_read_o    = (state_q == StBusy) & ~we_q;
    assign mem_write_o   = (state_q == StBusy) & we_q;
    assign mem_address_o = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign dm_rdata_o    = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with ACCESS_CYCLES=3, second with ACCESS_CYCLES=1.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (ACCESS_CYCLES=3, STARVE_LIMIT=4)
    logic        if_req, if_gnt, if_done, dm_req, dm_we, dm_gnt, dm_done;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem [16];

    // Second instance (ACCESS_CYCLES=1)
    logic        if_req1, if_gnt1, if_done1, dm_gnt1, dm_done1, mem_read1, mem_write1;
    logic [31:0] if_addr1, if_rdata1, dm_rdata1, mem_address1, mem_wdata1, mem_rdata1;
    logic        dm_req1 = 1'b0;
    logic        dm_we1 = 1'b0;
    logic [31:0] dm_addr1 = '0;
    logic [31:0] dm_wdata1 = '0;

    int n_checks = 0;
    int n_pass = 0;

    mem_arbiter #(.DATA_W(32), .ACCESS_CYCLES(3), .STARVE_LIMIT(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rdata_o(if_rdata), .if_done_o(if_done),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rdata_o(dm_rdata), .dm_done_o(dm_done),
        .mem_address_o(mem_address), .mem_wdata_o(mem_wdata),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.DATA_W(32), .ACCESS_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_gnt_o(if_gnt1),
        .if_rdata_o(if_rdata1), .if_done_o(if_done1),
        .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
        .dm_gnt_o(dm_gnt1), .dm_rdata_o(dm_rdata1), .dm_done_o(dm_done1),
        .mem_address_o(mem_address1), .mem_wdata_o(mem_wdata1),
        .mem_read_o(mem_read1), .mem_write_o(mem_write1), .mem_rdata_i(mem_rdata1)
    );

    // Word i of the main memory resets to 0x1000_0000 + i.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_write) begin
            mem[mem_address[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata  = mem[mem_address[3:0]];
    assign mem_rdata1 = (mem_address1 == 32'd5) ? 32'h0A11_0000 : 32'h0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int wcnt);
        dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
        lat = 0; wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            lat++;
            if (mem_write) wcnt++;
            if (dm_done) break;
        end
        dm_req = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({if_gnt, if_done, dm_gnt, dm_done, mem_read, mem_write} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {if_gnt, if_done, dm_gnt, dm_done, mem_read, mem_write});
        else n_pass++;
        n_checks++;
        if ({if_rdata, dm_rdata, mem_address, mem_wdata} !== 128'b0)
            $display("FAIL reset_data: got %h want 0", {if_rdata, dm_rdata, mem_address, mem_wdata});
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(); cyc();
        n_checks++;
        if ({if_gnt, dm_gnt, mem_read, mem_write, mem_address} !== 36'b0)
            $display("FAIL reset_idle: got %h want 0", {if_gnt, dm_gnt, mem_read, mem_write, mem_address});
        else n_pass++;
    endtask

    task automatic test_if_only();
        if_addr1 = 32'd5; if_req1 = 1'b1;
        cyc();
        if_req1 = 1'b0;
        n_checks++;
        if ({mem_read1, if_gnt1, dm_gnt1, if_done1} !== 4'b1100)
            $display("FAIL if_only_busy: got %b want 1100", {mem_read1, if_gnt1, dm_gnt1, if_done1});
        else n_pass++;
        cyc();
        n_checks++;
        if ({if_done1, mem_read1, dm_done1, dm_gnt1} !== 4'b1000)
            $display("FAIL if_only_resp: got %b want 1000", {if_done1, mem_read1, dm_done1, dm_gnt1});
        else n_pass++;
        n_checks++;
        if (if_rdata1 !== 32'h0A11_0000)
            $display("FAIL if_only_rdata: got %h want 0a110000", if_rdata1);
        else n_pass++;
        cyc();
        n_checks++;
        if ({if_done1, if_gnt1, dm_rdata1} !== 34'b0)
            $display("FAIL if_only_idle: got %h want 0", {if_done1, if_gnt1, dm_rdata1});
        else n_pass++;
    endtask

    task automatic test_dm_write_read();
        int lat, wcnt;
        dm_access(1'b1, 32'd9, 32'hDEAD_BEEF, lat, wcnt);
        n_checks++;
        if (wcnt !== 3) $display("FAIL wr_mem_write_cycles: got %0d want 3", wcnt);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL wr_latency: got %0d want 4", lat);
        else n_pass++;
        n_checks++;
        if (dm_rdata !== 32'h0) $display("FAIL wr_rdata_unchanged: got %h want 0", dm_rdata);
        else n_pass++;
        cyc();
        dm_access(1'b0, 32'd9, 32'h0, lat, wcnt);
        n_checks++;
        if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat);
        else n_pass++;
        n_checks++;
        if (dm_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h want deadbeef", dm_rdata);
        else n_pass++;
        n_checks++;
        if (if_rdata !== 32'h0) $display("FAIL rd_if_rdata_untouched: got %h want 0", if_rdata);
        else n_pass++;
        cyc();
    endtask

    task automatic test_starvation();
        logic       order [6];
        int         nd = 0;
        logic       both = 1'b0;
        logic [5:0] exp_order = 6'b101111;  // bit k = winner of access k (1 = DM)
        if_addr = 32'd1; dm_addr = 32'd2; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 100 && nd < 6; i++) begin
            cyc();
            if (if_gnt && dm_gnt) both = 1'b1;
            if (dm_done) begin order[nd] = 1'b1; nd++; end
            else if (if_done) begin order[nd] = 1'b0; nd++; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        n_checks++;
        if (nd !== 6) $display("FAIL starve_count: got %0d want 6", nd);
        else n_pass++;
        for (int k = 0; k < nd; k++) begin
            n_checks++;
            if (order[k] !== exp_order[k])
                $display("FAIL starve_order[%0d]: got %b want %b", k, order[k], exp_order[k]);
            else n_pass++;
        end
        n_checks++;
        if (both !== 1'b0) $display("FAIL starve_single_grant: got both=%b want 0", both);
        else n_pass++;
        n_checks++;
        if ({if_rdata, dm_rdata} !== {32'h1000_0001, 32'h1000_0002})
            $display("FAIL starve_rdata: got %h %h want 10000001 10000002", if_rdata, dm_rdata);
        else n_pass++;
        cyc();
    endtask

    task automatic test_operand_change();
        int nd = 0;
        logic [31:0] r1 = '0;
        dm_we = 1'b0; dm_addr = 32'd3; dm_req = 1'b1;
        cyc();
        dm_addr = 32'd7;
        cyc();
        n_checks++;
        if (mem_address !== 32'd3) $display("FAIL opchg_addr_held: got %0d want 3", mem_address);
        else n_pass++;
        for (int i = 0; i < 30 && nd < 2; i++) begin
            if (dm_done) begin
                nd++;
                if (nd == 1) r1 = dm_rdata;
            end
            if (nd < 2) cyc();
        end
        dm_req = 1'b0;
        n_checks++;
        if (r1 !== 32'h1000_0003) $display("FAIL opchg_first_result: got %h want 10000003", r1);
        else n_pass++;
        n_checks++;
        if ({dm_rdata, mem_address} !== {32'h1000_0007, 32'd7})
            $display("FAIL opchg_second: got %h addr %0d want 10000007 addr 7", dm_rdata, mem_address);
        else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        dm_we = 1'b1; dm_addr = 32'd4; dm_wdata = 32'h55AA_55AA; dm_req = 1'b1;
        cyc(); cyc();
        n_checks++;
        if (mem_write !== 1'b1) $display("FAIL rstmid_pre_write: got %b want 1", mem_write);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_write, dm_gnt, dm_done, mem_read} !== 4'b0)
            $display("FAIL rstmid_ctrl: got %b want 0000", {mem_write, dm_gnt, dm_done, mem_read});
        else n_pass++;
        n_checks++;
        if ({mem_address, mem_wdata, dm_rdata, if_rdata} !== 128'b0)
            $display("FAIL rstmid_data: got %h want 0", {mem_address, mem_wdata, dm_rdata, if_rdata});
        else n_pass++;
        dm_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (dm_done || if_done || dm_gnt || if_gnt || mem_read || mem_write) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rstmid_after_release: got activity=%b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t [4];
        int nd = 0;
        int rises = 0;
        int dmg = 0;
        logic prev = 1'b0;
        if_addr = 32'd6; if_req = 1'b1;
        for (int i = 1; i <= 60 && nd < 4; i++) begin
            cyc();
            if (if_gnt && !prev) rises++;
            prev = if_gnt;
            if (dm_gnt) dmg++;
            if (if_done) begin t[nd] = i; nd++; end
        end
        if_req = 1'b0;
        n_checks++;
        if (nd !== 4) $display("FAIL b2b_done_count: got %0d want 4", nd);
        else n_pass++;
        n_checks++;
        if (t[0] !== 4) $display("FAIL b2b_first_latency: got %0d want 4", t[0]);
        else n_pass++;
        for (int k = 1; k < nd; k++) begin
            n_checks++;
            if (t[k] - t[k-1] !== 5)
                $display("FAIL b2b_period[%0d]: got %0d want 5", k, t[k] - t[k-1]);
            else n_pass++;
        end
        n_checks++;
        if (rises !== nd) $display("FAIL b2b_gnt_per_access: got %0d want %0d", rises, nd);
        else n_pass++;
        n_checks++;
        if ({if_rdata, dm_rdata, 32'(dmg)} !== {32'h1000_0006, 32'h0, 32'h0})
            $display("FAIL b2b_rdata: got if=%h dm=%h dmgnt=%0d want 10000006 0 0",
                     if_rdata, dm_rdata, dmg);
        else n_pass++;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req1 = 1'b0; if_addr1 = '0;
        test_reset();
        test_if_only();
        test_dm_write_read();
        test_starvation();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
